fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/fetch_btb.sv | 61 ++++++
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, fetch-queue entry and address alignment helper.
package cpu_types_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
      word_t npc;
      logic  pred;
   } fetch_entry_t;

   function automatic word_t word_align(input word_t addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer. Lookup reads the current contents, so an update
// at the same index becomes visible on the following cycle.
module fetch_btb
   import cpu_types_pkg::*;
#(
   parameter int ENTRIES = 4
) (
   input  logic  CLK,
   input  logic  nRST,
   input  word_t lookup_pc,
   output logic  hit,
   output word_t target,
   input  logic  upd,
   input  word_t upd_pc,
   input  word_t upd_target,
   input  logic  upd_taken
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WORD_W - 2 - IDX_W;

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tags    [ENTRIES];
   word_t              targets [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] up_tag;
   logic             unused_low_bits;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[WORD_W-1:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[WORD_W-1:IDX_W+2];
   assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
   assign target = word_align(targets[lk_idx]);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= '0;
      end else if (upd) begin
         if (upd_taken) begin
            valid[up_idx] <= 1'b1;
         end else if (tags[up_idx] == up_tag) begin
            valid[up_idx] <= 1'b0;
         end
      end
   end

   // Tag/target storage needs no reset: entries are qualified by valid.
   always_ff @(posedge CLK) begin
      if (upd && upd_taken) begin
         tags[up_idx]    <= up_tag;
         targets[up_idx] <= upd_target;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, 2-entry fetch queue, flush/halt control.
// Optional branch prediction enabled by defining FETCH_BTB_EN.
module fetch_stage
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT     = 32'h0,
   parameter int    BTB_ENTRIES = 4
) (
   input  logic  CLK,
   input  logic  nRST,
   output logic  imemREN,
   output word_t imemaddr,
   input  logic  ihit,
   input  word_t imemload,
   input  logic  stall,
   input  logic  flush,
   input  word_t redirect_pc,
   input  logic  halt,
   output logic  out_valid,
   output word_t out_instr,
   output word_t out_pc,
   output word_t out_npc,
   output logic  out_pred_taken,
   input  logic  btb_upd,
   input  word_t btb_upd_pc,
   input  word_t btb_upd_target,
   input  logic  btb_upd_taken
);

   localparam word_t PC_RESET = {PC_INIT[WORD_W-1:2], 2'b00};

   word_t        pc;
   word_t        seq_pc;
   word_t        pred_next;
   logic         halted;
   logic [1:0]   count;
   logic         rd_ptr;
   logic         wr_ptr;
   logic         push;
   logic         pop;
   logic         btb_hit;
   word_t        btb_target;
   fetch_entry_t fifo_mem [2];
   fetch_entry_t head;
   fetch_entry_t new_entry;

`ifdef FETCH_BTB_EN
   fetch_btb #(
      .ENTRIES(BTB_ENTRIES)
   ) u_btb (
      .CLK        (CLK),
      .nRST       (nRST),
      .lookup_pc  (pc),
      .hit        (btb_hit),
      .target     (btb_target),
      .upd        (btb_upd),
      .upd_pc     (btb_upd_pc),
      .upd_target (btb_upd_target),
      .upd_taken  (btb_upd_taken)
   );
`else
   localparam int unused_btb_entries = BTB_ENTRIES;
   logic unused_btb_upd;

   assign unused_btb_upd = ^{btb_upd, btb_upd_pc, btb_upd_target, btb_upd_taken};
   assign btb_hit        = 1'b0;
   assign btb_target     = '0;
`endif

   assign seq_pc    = pc + 32'd4;
   assign pred_next = btb_hit ? btb_target : seq_pc;
   assign imemaddr  = pc;

   // Reset gates the request combinationally so an in-flight read is dropped at once.
   assign imemREN = nRST && !halted && !flush && (count != 2'd2);
   assign push    = imemREN && ihit;
   assign pop     = out_valid && !stall;

   assign new_entry = '{instr: imemload, pc: pc, npc: seq_pc, pred: btb_hit};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc     <= PC_RESET;
         halted <= 1'b0;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (halt) begin
            halted <= 1'b1;
         end
         if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            if (!halted) begin
               pc <= word_align(redirect_pc);
            end
         end else begin
            if (push) begin
               wr_ptr <= ~wr_ptr;
               pc     <= pred_next;
            end
            if (pop) begin
               rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Fetch queue storage: written only on push, qualified by count.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= new_entry;
      end
   end

   assign head      = fifo_mem[rd_ptr];
   assign out_valid = (count != 2'd0) && !halted;

   always_comb begin
      out_instr      = '0;
      out_pc         = '0;
      out_npc        = '0;
      out_pred_taken = 1'b0;
      if (out_valid) begin
         out_instr      = head.instr;
         out_pc         = head.pc;
         out_npc        = head.npc;
         out_pred_taken = head.pred;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: queue-based reference model, monitor compares presented head.
module tb_fetch_stage;

   localparam int BTB_N   = 4;
   localparam int BTB_LOG = 2;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_npc;
   logic        out_pred_taken;
   logic        btb_upd;
   logic [31:0] btb_upd_pc;
   logic [31:0] btb_upd_target;
   logic        btb_upd_taken;

   logic        w_ren;
   logic [31:0] w_addr;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;
   logic [31:0] w_npc;
   logic        w_pred;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_stage #(.PC_INIT(32'h0), .BTB_ENTRIES(BTB_N)) u_dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit),
      .imemload(imemload), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
      .halt(halt), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_npc(out_npc), .out_pred_taken(out_pred_taken), .btb_upd(btb_upd),
      .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken)
   );

   fetch_stage #(.PC_INIT(32'hFFFF_FFFC), .BTB_ENTRIES(BTB_N)) u_dut_wrap (
      .CLK(CLK), .nRST(nRST), .imemREN(w_ren), .imemaddr(w_addr), .ihit(ihit),
      .imemload(imemload), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
      .halt(halt), .out_valid(w_valid), .out_instr(w_instr), .out_pc(w_pc),
      .out_npc(w_npc), .out_pred_taken(w_pred), .btb_upd(btb_upd),
      .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] npc;
      bit          pred;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc;
   bit          m_halted;
`ifdef FETCH_BTB_EN
   bit          bv   [BTB_N];
   logic [31:0] btag [BTB_N];
   logic [31:0] btgt [BTB_N];
`endif

   function automatic bit m_ren();
      return nRST && !m_halted && !flush && (exp_q.size() < 2);
   endfunction

   function automatic bit m_valid();
      return (exp_q.size() > 0) && !m_halted;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_pc     = 32'h0;
      m_halted = 1'b0;
`ifdef FETCH_BTB_EN
      for (int i = 0; i < BTB_N; i++) bv[i] = 1'b0;
`endif
   endtask

   always @(posedge CLK) begin
      bit          ren;
      bit          pop;
      bit          push;
      bit          hit;
      logic [31:0] nxt;
      exp_t        e;
      int          idx;
      if (!nRST) begin
         model_reset();
      end else begin
         ren  = m_ren();
         pop  = m_valid() && !stall;
         push = ren && ihit;
         idx  = int'((m_pc >> 2) % BTB_N);
         hit  = 1'b0;
         nxt  = m_pc + 32'd4;
`ifdef FETCH_BTB_EN
         if (bv[idx] && btag[idx] == (m_pc >> (BTB_LOG + 2))) begin
            hit = 1'b1;
            nxt = btgt[idx] & 32'hFFFF_FFFC;
         end
`endif
         if (flush) begin
            exp_q.delete();
            if (!m_halted) m_pc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
               e.instr = imemload;
               e.pc    = m_pc;
               e.npc   = m_pc + 32'd4;
               e.pred  = hit;
               exp_q.push_back(e);
               m_pc = nxt;
            end
         end
         if (halt) m_halted = 1'b1;
`ifdef FETCH_BTB_EN
         if (btb_upd) begin
            idx = int'((btb_upd_pc >> 2) % BTB_N);
            if (btb_upd_taken) begin
               bv[idx]   = 1'b1;
               btag[idx] = btb_upd_pc >> (BTB_LOG + 2);
               btgt[idx] = btb_upd_target;
            end else if (btag[idx] == (btb_upd_pc >> (BTB_LOG + 2))) begin
               bv[idx] = 1'b0;
            end
         end
`endif
      end
   end

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         check("imemREN", {31'b0, imemREN}, {31'b0, m_ren()});
         if (m_ren()) check("imemaddr", imemaddr, m_pc);
         check("out_valid", {31'b0, out_valid}, {31'b0, m_valid()});
         if (out_valid && m_valid()) begin
            check("out_instr", out_instr, exp_q[0].instr);
            check("out_pc", out_pc, exp_q[0].pc);
            check("out_npc", out_npc, exp_q[0].npc);
            check("out_pred_taken", {31'b0, out_pred_taken}, {31'b0, exp_q[0].pred});
         end
         if (!nRST) begin
            check("rst_out_instr", out_instr, 32'h0);
            check("rst_out_pc", out_pc, 32'h0);
            check("rst_out_npc", out_npc, 32'h0);
            check("rst_out_pred", {31'b0, out_pred_taken}, 32'h0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge CLK);
      imemload = $urandom;
   endtask

   task automatic idle_inputs();
      ihit = 0; stall = 0; flush = 0; redirect_pc = 0; halt = 0;
      btb_upd = 0; btb_upd_pc = 0; btb_upd_target = 0; btb_upd_taken = 0;
   endtask

   initial begin
      logic [31:0] exp_addr;
      logic        exp_pred;
      nRST = 1'b0;
      imemload = 32'h0;
      idle_inputs();
      ihit = 1'b1;
      repeat (2) step();
      #1;
      check("reset_imemREN", {31'b0, imemREN}, 32'h0);
      check("reset_out_valid", {31'b0, out_valid}, 32'h0);
      check("reset_wrap_addr", w_addr, 32'hFFFF_FFFC);

      // straight-line fetch
      step();
      nRST = 1'b1;
      #1;
      check("first_addr", imemaddr, 32'h0);
      check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
      step();
      #1;
      check("second_addr", imemaddr, 32'h4);
      check("wrap_second_addr", w_addr, 32'h0);
      check("first_out_pc", out_pc, 32'h0);
      repeat (4) step();

      // backpressure fills the queue
      stall = 1'b1;
      repeat (3) step();
      #1;
      check("stall_full_ren", {31'b0, imemREN}, 32'h0);
      stall = 1'b0;
      repeat (4) step();

      // flush with coincident hit
      flush = 1'b1; redirect_pc = 32'h103;
      step();
      flush = 1'b0; ihit = 1'b0;
      #1;
      check("flush_addr", imemaddr, 32'h100);
      check("flush_empty", {31'b0, out_valid}, 32'h0);
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         ihit           = ($urandom_range(0, 3) != 0);
         stall          = ($urandom_range(0, 2) == 0);
         flush          = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom_range(0, 63);
         btb_upd        = ($urandom_range(0, 3) == 0);
         btb_upd_pc     = $urandom_range(0, 63);
         btb_upd_target = $urandom_range(0, 255);
         btb_upd_taken  = $urandom_range(0, 1);
         step();
      end
      idle_inputs();
      step();

      // BTB train, predict, untrain
      btb_upd = 1; btb_upd_pc = 32'h10; btb_upd_target = 32'h40; btb_upd_taken = 1;
      flush = 1; redirect_pc = 32'h10;
      step();
      idle_inputs();
      ihit = 1;
      #1;
      check("btb_fetch_addr", imemaddr, 32'h10);
      step();
      ihit = 0;
`ifdef FETCH_BTB_EN
      exp_addr = 32'h40; exp_pred = 1'b1;
`else
      exp_addr = 32'h14; exp_pred = 1'b0;
`endif
      #1;
      check("btb_pred_addr", imemaddr, exp_addr);
      check("btb_pred_taken", {31'b0, out_pred_taken}, {31'b0, exp_pred});
      btb_upd = 1; btb_upd_pc = 32'h10; btb_upd_target = 32'h40; btb_upd_taken = 0;
      flush = 1; redirect_pc = 32'h10;
      step();
      idle_inputs();
      ihit = 1;
      step();
      ihit = 0;
      #1;
      check("btb_untrain_addr", imemaddr, 32'h14);
      check("btb_untrain_pred", {31'b0, out_pred_taken}, 32'h0);
      step();

      // halt is sticky across flush
      ihit = 1; halt = 1;
      step();
      halt = 0;
      repeat (3) step();
      #1;
      check("halt_ren", {31'b0, imemREN}, 32'h0);
      check("halt_valid", {31'b0, out_valid}, 32'h0);
      flush = 1; redirect_pc = 32'h200;
      step();
      flush = 0;
      repeat (2) step();
      #1;
      check("halt_flush_ren", {31'b0, imemREN}, 32'h0);
      check("halt_flush_valid", {31'b0, out_valid}, 32'h0);

      // reset mid-request
      #2;
      nRST = 1'b0;
      #1;
      check("midrst_ren", {31'b0, imemREN}, 32'h0);
      check("midrst_out_pc", out_pc, 32'h0);
      step();
      step();
      nRST = 1'b1;
      #1;
      check("rel_addr", imemaddr, 32'h0);
      check("rel_ren", {31'b0, imemREN}, 32'h1);
      repeat (4) step();
      #1;
      check("rel_valid", {31'b0, out_valid}, 32'h1);
      idle_inputs();
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
